// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 32-bit shifter, one binary stage (16,8,4,2,1) per clock
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [1:0]  ctrl_shiftop,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic [31:0] data_operandA,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  logic [1:0]  state;
  logic [31:0] work;
  logic [4:0]  amt;
  logic [1:0]  op;
  logic [2:0]  stg;
  logic [31:0] stage_out;

  function automatic logic [31:0] stage_shift(input logic [31:0] w,
                                              input logic [1:0]  o,
                                              input logic [2:0]  k);
    logic [5:0]  s;
    logic [31:0] r;
    s = 6'd1 << k;
    case (o)
      OP_SLL:  r = w << s;
      OP_SRA:  r = $unsigned($signed(w) >>> s);
      OP_SRL:  r = w >> s;
      default: r = (w << s) | (w >> (6'd32 - s));
    endcase
    return r;
  endfunction

  always_comb begin
    stage_out = work;
    if (amt[stg])
      stage_out = stage_shift(work, op, stg);
  end

  // Accept is allowed from DONE as well as IDLE so back-to-back issue costs no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      work        <= 32'h0;
      amt         <= 5'd0;
      op          <= 2'b00;
      stg         <= 3'd4;
      data_result <= 32'h0;
    end else begin
      case (state)
        ST_SHIFT: begin
          work <= stage_out;
          if (stg == 3'd0) begin
            data_result <= stage_out;
            stg         <= 3'd4;
            state       <= ST_DONE;
          end else begin
            stg <= stg - 3'd1;
          end
        end
        default: begin
          if (ctrl_start) begin
            work  <= data_operandA;
            amt   <= ctrl_shiftamt;
            op    <= ctrl_shiftop;
            stg   <= 3'd4;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy           = (state == ST_SHIFT);
  assign data_resultRDY = (state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed-vector bench for shift_sequencer
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_shiftop;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_shiftop   (ctrl_shiftop),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Issues one op at the current negedge (cycle 0) and records cycles 1..8.
  task automatic run_op(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] a,
                        output logic [31:0] res, output logic [8:0] bseq, output logic [8:0] rseq);
    res  = 32'hx;
    bseq = '0;
    rseq = '0;
    ctrl_start    = 1'b1;
    ctrl_shiftop  = op;
    ctrl_shiftamt = amt;
    data_operandA = a;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) ctrl_start = 1'b0;
      bseq[c] = busy;
      rseq[c] = data_resultRDY;
      if (data_resultRDY && rseq[c-1 -: 1] !== 1'b1) res = data_result;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_start = 1'b0;
    ctrl_shiftop = 2'b00;
    ctrl_shiftamt = 5'd0;
    data_operandA = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", data_result); end
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    // reset and start together: start is dropped
    reset = 1'b1;
    ctrl_start = 1'b1;
    data_operandA = 32'h1;
    ctrl_shiftamt = 5'd3;
    @(negedge clock);
    reset = 1'b0;
    ctrl_start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_busy got=%b exp=0", busy); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_start_idle got busy=%b rdy=%b exp 0/0", busy, data_resultRDY); end
  endtask

  task automatic test_sll();
    logic [31:0] r;
    logic [8:0]  b, y;
    run_op(2'b00, 5'd31, 32'h00000001, r, b, y);
    n_cmp++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL sll_result got=%h exp=80000000", r); end
    n_cmp++; if (b !== 9'h03E) begin n_fail++; $display("FAIL sll_busy_seq got=%h exp=03e", b); end
    n_cmp++; if (y !== 9'h040) begin n_fail++; $display("FAIL sll_rdy_seq got=%h exp=040", y); end
  endtask

  task automatic test_sra_srl();
    logic [31:0] r;
    logic [8:0]  b, y;
    run_op(2'b01, 5'd4, 32'h80000000, r, b, y);
    n_cmp++; if (r !== 32'hF8000000) begin n_fail++; $display("FAIL sra_neg got=%h exp=f8000000", r); end
    run_op(2'b10, 5'd4, 32'h80000000, r, b, y);
    n_cmp++; if (r !== 32'h08000000) begin n_fail++; $display("FAIL srl got=%h exp=08000000", r); end
    n_cmp++; if (y !== 9'h040) begin n_fail++; $display("FAIL srl_rdy_seq got=%h exp=040", y); end
    run_op(2'b01, 5'd4, 32'h7FFFFFF0, r, b, y);
    n_cmp++; if (r !== 32'h07FFFFFF) begin n_fail++; $display("FAIL sra_pos got=%h exp=07ffffff", r); end
    run_op(2'b01, 5'd31, 32'hC0000000, r, b, y);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sra_31 got=%h exp=ffffffff", r); end
  endtask

  task automatic test_rotate_zero();
    logic [31:0] r;
    logic [8:0]  b, y;
    run_op(2'b11, 5'd1, 32'h80000001, r, b, y);
    n_cmp++; if (r !== 32'h00000003) begin n_fail++; $display("FAIL rol_1 got=%h exp=00000003", r); end
    run_op(2'b11, 5'd16, 32'h12345678, r, b, y);
    n_cmp++; if (r !== 32'h56781234) begin n_fail++; $display("FAIL rol_16 got=%h exp=56781234", r); end
    for (int o = 0; o < 4; o++) begin
      run_op(o[1:0], 5'd0, 32'hDEADBEEF, r, b, y);
      n_cmp++; if (r !== 32'hDEADBEEF || y !== 9'h040) begin n_fail++; $display("FAIL amt0_op%0d got=%h rdy=%h exp=deadbeef rdy=040", o, r, y); end
    end
  endtask

  task automatic test_start_while_busy();
    int          pulses = 0;
    int          rdy_cyc = -1;
    logic [31:0] r = 32'hx;
    ctrl_start    = 1'b1;
    ctrl_shiftop  = 2'b00;
    ctrl_shiftamt = 5'd4;
    data_operandA = 32'h00000001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) begin
        ctrl_start = 1'b0; ctrl_shiftop = 2'b10; ctrl_shiftamt = 5'd1; data_operandA = 32'hFFFFFFFF;
      end
      if (c == 3) begin
        ctrl_start = 1'b1; ctrl_shiftop = 2'b11; ctrl_shiftamt = 5'd7; data_operandA = 32'hAAAA5555;
      end
      if (c == 4) ctrl_start = 1'b0;
      if (data_resultRDY) begin
        pulses++;
        if (rdy_cyc < 0) begin rdy_cyc = c; r = data_result; end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_start_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (rdy_cyc !== 6) begin n_fail++; $display("FAIL busy_start_cycle got=%0d exp=6", rdy_cyc); end
    n_cmp++; if (r !== 32'h00000010) begin n_fail++; $display("FAIL busy_start_result got=%h exp=00000010", r); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] b = '0;
    logic [13:0] y = '0;
    ctrl_start    = 1'b1;
    ctrl_shiftop  = 2'b00;
    ctrl_shiftamt = 5'd2;
    data_operandA = 32'h00000001;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clock);
      b[c] = busy;
      y[c] = data_resultRDY;
      if (c == 1) ctrl_start = 1'b0;
      if (c == 6) begin
        n_cmp++; if (data_result !== 32'h00000004) begin n_fail++; $display("FAIL b2b_first got=%h exp=00000004", data_result); end
        ctrl_start = 1'b1; ctrl_shiftop = 2'b10; ctrl_shiftamt = 5'd8; data_operandA = 32'h00000100;
      end
      if (c == 7) ctrl_start = 1'b0;
      if (c == 10) begin
        n_cmp++; if (data_result !== 32'h00000004) begin n_fail++; $display("FAIL b2b_hold got=%h exp=00000004", data_result); end
      end
      if (c == 12) begin
        n_cmp++; if (data_result !== 32'h00000001) begin n_fail++; $display("FAIL b2b_second got=%h exp=00000001", data_result); end
      end
    end
    n_cmp++; if (b !== 14'h0FBE) begin n_fail++; $display("FAIL b2b_busy_seq got=%h exp=0fbe", b); end
    n_cmp++; if (y !== 14'h1040) begin n_fail++; $display("FAIL b2b_rdy_seq got=%h exp=1040", y); end
  endtask

  task automatic test_reset_mid();
    int          pulses = 0;
    logic [31:0] r;
    logic [8:0]  b, y;
    ctrl_start    = 1'b1;
    ctrl_shiftop  = 2'b00;
    ctrl_shiftamt = 5'd31;
    data_operandA = 32'h00000001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) ctrl_start = 1'b0;
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'h0) begin
          n_fail++; $display("FAIL rst_mid_outputs got busy=%b rdy=%b res=%h exp 0/0/00000000", busy, data_resultRDY, data_result);
        end
      end
      if (c >= 4 && data_resultRDY) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses); end
    run_op(2'b11, 5'd4, 32'h12345678, r, b, y);
    n_cmp++; if (r !== 32'h23456781 || y !== 9'h040) begin n_fail++; $display("FAIL rst_mid_after got=%h rdy=%h exp=23456781 rdy=040", r, y); end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rotate_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
